// File: rtl/dvi_in_pkg.sv
// Shared types for the DVI link controller: link FSM state encoding and helpers.
package dvi_in_pkg;

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StHpdLow     = 3'd1,
        StWaitLock   = 3'd2,
        StWaitFrames = 3'd3,
        StUp         = 3'd4,
        StFail       = 3'd5
    } link_state_e;

    localparam int unsigned RetryW = 8;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dvi_link_timer.sv
// Saturating cycle timer; expired_o flags the last cycle of a tc_i-cycle window.
module dvi_link_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [Width-1:0] tc_i,
    output logic             expired_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts completed cycles, so the tc_i-th cycle sees tc_i - 1.
    assign expired_o = en_i && (cnt_q >= (tc_i - Width'(1)));

endmodule

// File: rtl/dvi_link_ctrl.sv
// DVI sink link bring-up controller: hot-plug pulse, PLL lock wait, frame qualification.
module dvi_link_ctrl
    import dvi_in_pkg::*;
#(
    parameter int unsigned HPD_LOW_CYCLES = 50000000,
    parameter int unsigned LOCK_TIMEOUT   = 10000000,
    parameter int unsigned FRAME_TIMEOUT  = 5000000,
    parameter int unsigned FRAMES_REQ     = 4,
    parameter int unsigned MAX_RETRIES    = 7
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              pll_locked_i,
    input  logic              frame_valid_i,
    output logic              hpa_o,
    output logic              txen_o,
    output logic              pll_rst_o,
    output logic              link_up_o,
    output logic [2:0]        state_o,
    output logic [RetryW-1:0] retry_cnt_o,
    output logic              irq_link_up_o,
    output logic              irq_link_lost_o,
    output logic              irq_fail_o
);

    localparam int unsigned MaxTimeout = max3(HPD_LOW_CYCLES, LOCK_TIMEOUT, FRAME_TIMEOUT);
    localparam int unsigned TimerW     = $clog2(MaxTimeout) + 1;
    localparam int unsigned FrameW     = $clog2(FRAMES_REQ + 1);

    link_state_e       state_q, state_d;
    logic [FrameW-1:0] frames_q, frames_d, frames_inc;
    logic [RetryW-1:0] retry_q, retry_d, retry_inc;
    logic              hpa_q, pll_rst_q, link_up_q;
    logic              irq_up_q, irq_lost_q, irq_fail_q;
    logic              irq_up_d, irq_lost_d, irq_fail_d;
    logic              attempt_fail, frame_clr;
    logic              timer_clr, timer_en, expired;
    logic [TimerW-1:0] timer_tc;
    logic              active_d;

    assign frames_inc = frames_q + FrameW'(1);
    assign retry_inc  = (retry_q == '1) ? retry_q : retry_q + RetryW'(1);

    always_comb begin
        timer_en = 1'b1;
        timer_tc = TimerW'(FRAME_TIMEOUT);
        unique case (state_q)
            StHpdLow:           timer_tc = TimerW'(HPD_LOW_CYCLES);
            StWaitLock:         timer_tc = TimerW'(LOCK_TIMEOUT);
            StWaitFrames, StUp: timer_tc = TimerW'(FRAME_TIMEOUT);
            default:            timer_en = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        frames_d     = frames_q;
        retry_d      = retry_q;
        irq_up_d     = 1'b0;
        irq_lost_d   = 1'b0;
        irq_fail_d   = 1'b0;
        attempt_fail = 1'b0;
        frame_clr    = 1'b0;
        if (!enable_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StHpdLow;
                    retry_d = '0;
                end
                StHpdLow: if (expired) state_d = StWaitLock;
                StWaitLock: begin
                    if (pll_locked_i) begin
                        state_d  = StWaitFrames;
                        frames_d = '0;
                    end else if (expired) begin
                        attempt_fail = 1'b1;
                    end
                end
                // Lock loss beats a frame pulse; a frame pulse beats the timeout.
                StWaitFrames: begin
                    if (!pll_locked_i) begin
                        attempt_fail = 1'b1;
                    end else if (frame_valid_i) begin
                        frames_d  = frames_inc;
                        frame_clr = 1'b1;
                        if (frames_inc == FrameW'(FRAMES_REQ)) begin
                            state_d  = StUp;
                            irq_up_d = 1'b1;
                        end
                    end else if (expired) begin
                        attempt_fail = 1'b1;
                    end
                end
                StUp: begin
                    if (!pll_locked_i || (!frame_valid_i && expired)) begin
                        state_d    = StHpdLow;
                        retry_d    = '0;
                        irq_lost_d = 1'b1;
                    end else if (frame_valid_i) begin
                        frame_clr = 1'b1;
                    end
                end
                StFail:  state_d = StFail;
                default: state_d = StIdle;
            endcase
            if (attempt_fail) begin
                retry_d = retry_inc;
                if (retry_inc == RetryW'(MAX_RETRIES)) begin
                    state_d    = StFail;
                    irq_fail_d = 1'b1;
                end else begin
                    state_d = StHpdLow;
                end
            end
        end
    end

    assign timer_clr = frame_clr || (state_d != state_q);
    assign active_d  = (state_d == StWaitLock) || (state_d == StWaitFrames) || (state_d == StUp);

    dvi_link_timer #(
        .Width(TimerW)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (timer_clr),
        .en_i     (timer_en),
        .tc_i     (timer_tc),
        .expired_o(expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            frames_q   <= '0;
            retry_q    <= '0;
            hpa_q      <= 1'b0;
            pll_rst_q  <= 1'b1;
            link_up_q  <= 1'b0;
            irq_up_q   <= 1'b0;
            irq_lost_q <= 1'b0;
            irq_fail_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            frames_q   <= frames_d;
            retry_q    <= retry_d;
            hpa_q      <= active_d;
            pll_rst_q  <= !active_d;
            link_up_q  <= (state_d == StUp);
            irq_up_q   <= irq_up_d;
            irq_lost_q <= irq_lost_d;
            irq_fail_q <= irq_fail_d;
        end
    end

    assign state_o         = state_q;
    assign retry_cnt_o     = retry_q;
    assign hpa_o           = hpa_q;
    assign txen_o          = hpa_q;
    assign pll_rst_o       = pll_rst_q;
    assign link_up_o       = link_up_q;
    assign irq_link_up_o   = irq_up_q;
    assign irq_link_lost_o = irq_lost_q;
    assign irq_fail_o      = irq_fail_q;

endmodule

// File: tb/tb_dvi_link_ctrl.sv
// Bench for dvi_link_ctrl: directed bring-up/loss/fail scenarios plus random traffic vs a model.
module tb_dvi_link_ctrl;

    localparam int HPD_N   = 10;
    localparam int LOCK_N  = 20;
    localparam int FRAME_N = 30;
    localparam int FREQ    = 2;
    localparam int MAXR    = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       lock = 1'b0;
    logic       frame = 1'b0;
    logic       hpa_o, txen_o, pll_rst_o, link_up_o;
    logic [2:0] state_o;
    logic [7:0] retry_cnt_o;
    logic       irq_link_up_o, irq_link_lost_o, irq_fail_o;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    dvi_link_ctrl #(
        .HPD_LOW_CYCLES(HPD_N),
        .LOCK_TIMEOUT  (LOCK_N),
        .FRAME_TIMEOUT (FRAME_N),
        .FRAMES_REQ    (FREQ),
        .MAX_RETRIES   (MAXR)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (enable),
        .pll_locked_i   (lock),
        .frame_valid_i  (frame),
        .hpa_o          (hpa_o),
        .txen_o         (txen_o),
        .pll_rst_o      (pll_rst_o),
        .link_up_o      (link_up_o),
        .state_o        (state_o),
        .retry_cnt_o    (retry_cnt_o),
        .irq_link_up_o  (irq_link_up_o),
        .irq_link_lost_o(irq_link_lost_o),
        .irq_fail_o     (irq_fail_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: age = 1-based index of the current cycle within the timing window.
    typedef struct {
        int st;
        int age;
        int frames;
        int retry;
        bit iu;
        bit il;
        bit ifl;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t fail_attempt(input mdl_t cur, input mdl_t nx);
        mdl_t r = nx;
        r.retry = (cur.retry >= 255) ? 255 : cur.retry + 1;
        r.age   = 1;
        if (r.retry == MAXR) begin
            r.st  = 5;
            r.ifl = 1'b1;
        end else begin
            r.st = 1;
        end
        return r;
    endfunction

    function automatic mdl_t model_next(input mdl_t c, input bit en, input bit lk, input bit fv);
        mdl_t x = c;
        x.iu  = 1'b0;
        x.il  = 1'b0;
        x.ifl = 1'b0;
        x.age = c.age + 1;
        if (!en) begin
            x.st = 0;
            return x;
        end
        case (c.st)
            0: begin x.st = 1; x.age = 1; x.retry = 0; end
            1: if (c.age >= HPD_N) begin x.st = 2; x.age = 1; end
            2: begin
                if (lk) begin x.st = 3; x.age = 1; x.frames = 0; end
                else if (c.age >= LOCK_N) x = fail_attempt(c, x);
            end
            3: begin
                if (!lk) x = fail_attempt(c, x);
                else if (fv) begin
                    x.frames = c.frames + 1;
                    x.age    = 1;
                    if (x.frames == FREQ) begin x.st = 4; x.iu = 1'b1; end
                end else if (c.age >= FRAME_N) x = fail_attempt(c, x);
            end
            4: begin
                if (!lk || (!fv && c.age >= FRAME_N)) begin
                    x.st = 1; x.age = 1; x.retry = 0; x.il = 1'b1;
                end else if (fv) x.age = 1;
            end
            default: ;
        endcase
        return x;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{st: 0, age: 0, frames: 0, retry: 0, iu: 1'b0, il: 1'b0, ifl: 1'b0};
        else        m <= model_next(m, enable, lock, frame);
    end

    always @(negedge clk) begin
        chk("state", int'(state_o), m.st);
        chk("hpa", int'(hpa_o), int'(m.st >= 2 && m.st <= 4));
        chk("txen", int'(txen_o), int'(m.st >= 2 && m.st <= 4));
        chk("pll_rst", int'(pll_rst_o), int'(!(m.st >= 2 && m.st <= 4)));
        chk("link_up", int'(link_up_o), int'(m.st == 4));
        chk("retry", int'(retry_cnt_o), m.retry);
        chk("irq_up", int'(irq_link_up_o), int'(m.iu));
        chk("irq_lost", int'(irq_link_lost_o), int'(m.il));
        chk("irq_fail", int'(irq_fail_o), int'(m.ifl));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse();
        frame = 1'b1;
        step();
        frame = 1'b0;
    endtask

    task automatic wait_state(input int st, input int budget, input string name);
        int k = 0;
        while (int'(state_o) != st && k < budget) begin
            step();
            k++;
        end
        chk(name, int'(state_o), st);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, int'(state_o), 0);
        chk({tag, "_hpa"}, int'(hpa_o), 0);
        chk({tag, "_txen"}, int'(txen_o), 0);
        chk({tag, "_pllrst"}, int'(pll_rst_o), 1);
        chk({tag, "_linkup"}, int'(link_up_o), 0);
        chk({tag, "_retry"}, int'(retry_cnt_o), 0);
        chk({tag, "_irqs"}, int'({irq_link_up_o, irq_link_lost_o, irq_fail_o}), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        chk_reset_vals("por");
        rst_n = 1'b1;
        step();
        chk("idle_hold", int'(state_o), 0);

        // Nominal bring-up
        enable = 1'b1;
        wait_state(1, 5, "to_hpd");
        n = 0;
        while (state_o == 3'd1 && n < 50) begin step(); n++; end
        chk("hpd_len", n, 10);
        chk("wl_hpa", int'(hpa_o), 1);
        chk("wl_pllrst", int'(pll_rst_o), 0);
        repeat (4) step();
        lock = 1'b1;
        step();
        chk("to_wf", int'(state_o), 3);
        repeat (9) step();
        pulse();
        chk("wf_after1", int'(state_o), 3);
        repeat (9) step();
        pulse();
        chk("up_state", int'(state_o), 4);
        chk("up_link", int'(link_up_o), 1);
        chk("up_irq", int'(irq_link_up_o), 1);
        step();
        chk("up_irq_once", int'(irq_link_up_o), 0);

        // Pulse on the 30th cycle keeps the link, then starve it
        pulse();
        repeat (29) step();
        pulse();
        chk("edge_pulse_keeps", int'(state_o), 4);
        n = 0;
        while (state_o == 3'd4 && n < 60) begin step(); n++; end
        chk("starve_len", n, 30);
        chk("starve_irq", int'(irq_link_lost_o), 1);
        chk("starve_state", int'(state_o), 1);

        // Re-establish, then drop lock while UP
        wait_state(3, 30, "relock_wf");
        pulse();
        repeat (5) step();
        pulse();
        chk("reup", int'(state_o), 4);
        lock = 1'b0;
        step();
        chk("loss_state", int'(state_o), 1);
        chk("loss_irq", int'(irq_link_lost_o), 1);
        chk("loss_retry", int'(retry_cnt_o), 0);
        n = 0;
        while (hpa_o == 1'b0 && n < 50) begin step(); n++; end
        chk("loss_hpa_low", n, 10);

        // Lock never arrives: retries 1, 2, then FAIL at 3
        wait_state(1, 40, "retry1_hpd");
        chk("retry1", int'(retry_cnt_o), 1);
        wait_state(2, 40, "retry2_wl");
        wait_state(1, 40, "retry2_hpd");
        chk("retry2", int'(retry_cnt_o), 2);
        wait_state(2, 40, "retry3_wl");
        wait_state(5, 40, "to_fail");
        chk("fail_retry", int'(retry_cnt_o), 3);
        chk("fail_irq", int'(irq_fail_o), 1);
        chk("fail_hpa", int'(hpa_o), 0);
        repeat (5) step();
        chk("fail_stay", int'(state_o), 5);
        chk("fail_irq_once", int'(irq_fail_o), 0);
        enable = 1'b0;
        step();
        chk("fail_exit", int'(state_o), 0);
        chk("fail_exit_irqs", int'({irq_link_up_o, irq_link_lost_o, irq_fail_o}), 0);

        // Asynchronous reset in the middle of WAIT_FRAMES
        enable = 1'b1;
        lock = 1'b1;
        wait_state(3, 30, "pre_rst_wf");
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async");
        step();
        chk("rst_hold", int'(state_o), 0);
        rst_n = 1'b1;
        step();
        chk("rst_release", int'(state_o), 1);

        // Random traffic against the model
        for (int i = 0; i < 5000; i++) begin
            enable = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 24) == 0) lock = ~lock;
            frame = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dvi_link_ctrl.md
DVI_LINK_CTRL -- requirements
Module: dvi_link_ctrl

Interface
REQ-001 SHALL have parameter HPD_LOW_CYCLES, default 50000000, meaning the hot-plug deassert hold time in clk_i cycles (>=2).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 10000000, meaning the maximum number of cycles to wait for PLL lock.
REQ-003 SHALL have parameter FRAME_TIMEOUT, default 5000000, meaning the maximum number of cycles between valid-frame pulses.
REQ-004 SHALL have parameter FRAMES_REQ, default 4, meaning the number of consecutive valid frames needed for link up (>=1).
REQ-005 SHALL have parameter MAX_RETRIES, default 7, meaning the number of failed attempts before FAIL (1..255).
REQ-006 SHALL have the following ports: clk_i input 1 single clock; rst_ni input 1 asynchronous active-low reset.
REQ-007 SHALL have the following ports: enable_i input 1 level, link bring-up requested; pll_locked_i input 1 synchronous TMDS PLL lock level.
REQ-008 SHALL have the following ports: frame_valid_i input 1 one-cycle pulse per valid frame; hpa_o output 1 hot-plug assert; txen_o output 1 TMDS receiver enable.
REQ-009 SHALL have the following ports: pll_rst_o output 1 PLL reset; link_up_o output 1; state_o output 3 encoded FSM state; retry_cnt_o output 8.
REQ-010 SHALL have the following ports: irq_link_up_o output 1 pulse; irq_link_lost_o output 1 pulse; irq_fail_o output 1 pulse.

Function
REQ-011 FSM states SHALL be IDLE=0, HPD_LOW=1, WAIT_LOCK=2, WAIT_FRAMES=3, UP=4, FAIL=5, and state_o SHALL equal the registered state.
REQ-012 IDLE: hpa_o=0, txen_o=0, pll_rst_o=1, and when enable_i=1 the FSM SHALL move to HPD_LOW, clear the timer and clear retry_cnt_o.
REQ-013 HPD_LOW: hpa_o=0, txen_o=0, pll_rst_o=1, and after exactly HPD_LOW_CYCLES cycles in the state the FSM SHALL go to WAIT_LOCK.
REQ-014 WAIT_LOCK: hpa_o=1, txen_o=1, pll_rst_o=0, and pll_locked_i=1 SHALL move the FSM to WAIT_FRAMES with the timer and frame counter cleared.
REQ-015 WAIT_LOCK: after LOCK_TIMEOUT cycles without lock, this SHALL be a failed attempt.
REQ-016 WAIT_FRAMES: outputs SHALL be as in WAIT_LOCK, and each frame_valid_i pulse SHALL increment the frame counter and clear the timer.
REQ-017 WAIT_FRAMES: when the counter reaches FRAMES_REQ, the FSM SHALL move to UP, and irq_link_up_o SHALL pulse for one cycle on entry.
REQ-018 WAIT_FRAMES: pll_locked_i=0, or FRAME_TIMEOUT cycles without a pulse, SHALL be a failed attempt.
REQ-019 UP: link_up_o=1, and each frame_valid_i SHALL clear the timer.
REQ-020 UP: pll_locked_i=0, or FRAME_TIMEOUT cycles without a pulse, SHALL cause one irq_link_lost_o pulse, clear retry_cnt_o, and move the FSM to HPD_LOW (not counted as a failure).
REQ-021 A failed attempt SHALL increment retry_cnt_o, which saturates at 255; if the new value equals MAX_RETRIES, the FSM SHALL go to FAIL and pulse irq_fail_o once, otherwise it SHALL go to HPD_LOW.
REQ-022 FAIL: hpa_o=0, txen_o=0, pll_rst_o=1; the FSM SHALL stay in FAIL until enable_i=0.
REQ-023 enable_i=0 in any state SHALL move the FSM to IDLE on the next edge and take priority over all other transitions; no irq SHALL be raised.
REQ-024 When a frame_valid_i pulse and a timeout expiry occur in the same cycle, the pulse SHALL win and the timeout SHALL not fire.
REQ-025 When lock loss and a frame pulse occur in the same cycle, lock loss SHALL win.
REQ-026 All outputs SHALL be registered, so each output changes one cycle after the causing input edge.
REQ-027 Timer width SHALL be $clog2 of the largest timeout plus 1, and the timer SHALL never wrap because it saturates at its maximum.

Reset
REQ-028 Asserting rst_ni SHALL immediately force state IDLE, hpa_o=0, txen_o=0, pll_rst_o=1, link_up_o=0, retry_cnt_o=0, all irqs=0, and timer and frame counter=0.
REQ-029 Reset applied in the middle of any state SHALL behave identically to power-on reset.

Structure
REQ-030 The state enum SHALL be defined in the shared package dvi_in_pkg as link_state_e, 3 bits.
REQ-031 The timeout counter SHALL be the sub-module dvi_link_timer (clear, enable, terminal count, expired flag).

Verification
REQ-032 Nominal bring-up with HPD_LOW=10, LOCK=20, FRAME=30, FRAMES_REQ=2: enable=1, lock at cycle 15, and pulses every 10 cycles -> state 1->2->3->4, link_up_o=1 one cycle after the second pulse, and a single irq_link_up_o.
REQ-033 Lock timeout, MAX_RETRIES=3, lock never asserted -> three HPD_LOW/WAIT_LOCK cycles with retry_cnt 1,2,3, then FAIL, one irq_fail_o, and hpa_o=0.
REQ-034 Link loss: drop pll_locked_i while UP -> irq_link_lost_o pulse, state 1, retry_cnt_o=0, and hpa_o low for exactly 10 cycles.
REQ-035 Frame starvation: stop pulses while UP -> link lost exactly 30 cycles after the last pulse; a pulse on cycle 30 keeps the link UP.
REQ-036 Asynchronous reset asserted mid-WAIT_FRAMES, and separately enable_i dropped while in FAIL -> reset values immediately; IDLE next cycle; no irq.
